// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg
//   Definitions shared by the MEM/WB pipeline stage: the occupancy state
//   encoding, the default register-address width and the layout of one
//   MEM/WB entry (at default widths).
package mem_wb_pipe_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipeState_t;

    // One MEM/WB entry. The writeback value is already selected and the
    // write enable already masked for r0 when the entry is captured.
    typedef struct packed {
        logic                  valid;
        logic                  regWrite;
        logic [REG_AW_DEF-1:0] writeReg;
        logic [DATA_W_DEF-1:0] wbData;
    } wbEntry_t;

endpackage

// File: rtl/wb_entry_reg.sv
// wb_entry_reg
//   One MEM/WB entry register: valid bit plus writeback data, destination
//   and write enable. Used for both the head and the skid slot.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears everything)
//   load            capture the load* fields and set valid
//   clearValid      drop valid; data fields keep their contents
//   loadWbData/loadWriteReg/loadRegWrite   fields to capture
//   valid/wbData/writeReg/regWrite         stored entry
module wb_entry_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clearValid,
    input  logic [DATA_W-1:0] loadWbData,
    input  logic [REG_AW-1:0] loadWriteReg,
    input  logic              loadRegWrite,
    output logic              valid,
    output logic [DATA_W-1:0] wbData,
    output logic [REG_AW-1:0] writeReg,
    output logic              regWrite
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            wbData   <= '0;
            writeReg <= '0;
            regWrite <= 1'b0;
        end else begin
            // clearValid wins so a kill is never undone by a same-cycle load.
            if (clearValid) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
            if (load) begin
                wbData   <= loadWbData;
                writeReg <= loadWriteReg;
                regWrite <= loadRegWrite;
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe
//   MEM/WB pipeline stage built as a two-entry skid buffer (head + skid)
//   with valid/ready flow control, synchronous flush, writeback data
//   selection, r0 write suppression, a forwarding tap and a saturating
//   stall counter.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            upstream handshake (in_ready is a flop)
//   in_read_data, in_alu_result    writeback candidates
//   in_mem_to_reg                  1 selects load data
//   in_write_reg, in_reg_write     destination and write enable
//   flush                          kill all held entries
//   out_valid / out_ready          downstream handshake
//   out_write_reg, out_reg_write, out_wb_data   head entry
//   fwd_valid, fwd_reg, fwd_data   forwarding tap of the head entry
//   stall_cnt                      saturating count of out_valid & !out_ready
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_read_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [REG_AW-1:0] in_write_reg,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_write_reg,
    output logic              out_reg_write,
    output logic [DATA_W-1:0] out_wb_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    pipeState_t state, nextState;

    logic              headLoad, headFromSkid, headClear;
    logic              skidLoad, skidClear;
    logic              accept, pop;

    logic              headValid, headRegWrite;
    logic [DATA_W-1:0] headWbData;
    logic [REG_AW-1:0] headWriteReg;
    logic              skidValid, skidRegWrite;
    logic [DATA_W-1:0] skidWbData;
    logic [REG_AW-1:0] skidWriteReg;

    logic [DATA_W-1:0] wbData_p0;
    logic              regWrite_p0;
    logic [DATA_W-1:0] headWbDataIn;
    logic [REG_AW-1:0] headWriteRegIn;
    logic              headRegWriteIn;

    logic [CNT_W-1:0]  stallCount;

    // ---- capture stage (p0): entry fields computed from MEM inputs ----
    assign wbData_p0   = in_mem_to_reg ? in_read_data : in_alu_result;
    assign regWrite_p0 = in_reg_write & (in_write_reg != '0);

    assign accept = in_valid & in_ready;
    assign pop    = headValid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        headLoad     = 1'b0;
        headFromSkid = 1'b0;
        headClear    = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        if (flush) begin
            // Any same-cycle accept is dropped; data fields stay untouched.
            nextState = EMPTY;
            headClear = 1'b1;
            skidClear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        nextState = ONE;
                        headLoad  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        headLoad = 1'b1;
                    end else if (accept) begin
                        nextState = TWO;
                        skidLoad  = 1'b1;
                    end else if (pop) begin
                        nextState = EMPTY;
                        headClear = 1'b1;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        nextState    = ONE;
                        headLoad     = 1'b1;
                        headFromSkid = 1'b1;
                        skidClear    = 1'b1;
                    end
                end
                default: begin
                    nextState = EMPTY;
                    headClear = 1'b1;
                    skidClear = 1'b1;
                end
            endcase
        end
    end

    assign headWbDataIn   = headFromSkid ? skidWbData   : wbData_p0;
    assign headWriteRegIn = headFromSkid ? skidWriteReg : in_write_reg;
    assign headRegWriteIn = headFromSkid ? skidRegWrite : regWrite_p0;

    // ---- writeback stage (p1): head and skid entry registers ----
    wb_entry_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) headReg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (headLoad),
        .clearValid   (headClear),
        .loadWbData   (headWbDataIn),
        .loadWriteReg (headWriteRegIn),
        .loadRegWrite (headRegWriteIn),
        .valid        (headValid),
        .wbData       (headWbData),
        .writeReg     (headWriteReg),
        .regWrite     (headRegWrite)
    );

    wb_entry_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) skidReg (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (skidLoad),
        .clearValid   (skidClear),
        .loadWbData   (wbData_p0),
        .loadWriteReg (in_write_reg),
        .loadRegWrite (regWrite_p0),
        .valid        (skidValid),
        .wbData       (skidWbData),
        .writeReg     (skidWriteReg),
        .regWrite     (skidRegWrite)
    );

    // Not cleared by flush: it measures downstream backpressure since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (headValid && !out_ready) begin
            stallCount <= satInc(stallCount);
        end
    end

    // in_ready depends only on the skid flop, so a downstream stall reaches
    // upstream one cycle late and the skid slot absorbs the extra entry.
    assign in_ready      = ~skidValid;
    assign out_valid     = headValid;
    assign out_write_reg = headWriteReg;
    assign out_reg_write = headRegWrite;
    assign out_wb_data   = headWbData;
    assign fwd_valid     = headValid & headRegWrite;
    assign fwd_reg       = headWriteReg;
    assign fwd_data      = headWbData;
    assign stall_cnt     = stallCount;

endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline stage: a two-entry skid-buffered register between the memory stage and register-file writeback. Compared with a single-level pipeline register, it adds a valid/ready handshake for backpressure in both directions, a synchronous flush, writeback-data selection, an `r0` write suppression, a forwarding tap and a saturating stall counter. Sits between the data-cache/MEM stage and the register file.

## Interface
- `DATA_W`, 32, width of read data, ALU result and writeback data
- `REG_AW`, 5, register-address width
- `CNT_W`, 16, stall-counter width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  MEM stage presents a completed result (cache hit or non-memory op)
- `in_ready`  out  1  stage can accept; registered, equals !skid_valid
- `in_read_data`  in  DATA_W  load data
- `in_alu_result`  in  DATA_W  ALU result / address
- `in_write_reg`  in  REG_AW  destination register
- `in_reg_write`  in  1  write-enable
- `in_mem_to_reg`  in  1  1 selects load data for writeback
- `flush`  in  1  synchronous kill of all held entries
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  writeback consumes head this cycle
- `out_write_reg`  out  REG_AW  head destination
- `out_reg_write`  out  1  head write-enable, forced 0 when destination is 0
- `out_wb_data`  out  DATA_W  `mem_to_reg ? read_data : alu_result`, registered on capture
- `fwd_valid`  out  1  out_valid & out_reg_write
- `fwd_reg`, `fwd_data`  out  REG_AW / DATA_W  equal `out_write_reg` and `out_wb_data`
- `stall_cnt`  out  CNT_W  cycles with out_valid & !out_ready, saturating

## Operation
- Storage: head entry (drives outputs) plus skid entry. Each entry holds a valid bit, `wb_data`, `write_reg` and `reg_write`.
- Fields are computed at capture. `reg_write` is stored as `in_reg_write & (in_write_reg != 0)`.
- Accept when `in_valid & in_ready`. Pop when `out_valid & out_ready`.
- States: EMPTY (no entries), ONE (head only), TWO (head and skid).
  - EMPTY: accept -> ONE, input goes to head.
  - ONE: accept without pop -> TWO, input goes to skid. Accept with pop -> ONE, input replaces head. Pop only -> EMPTY.
  - TWO: in_ready = 0, so no accept. Pop -> ONE, skid moves to head and skid is cleared.
- Order is strictly FIFO. An entry is never duplicated or dropped except by flush.
- flush: next state EMPTY and both valid bits cleared. An accept in the same cycle is discarded. flush has priority over accept and pop. Data fields keep their values; only the valid bits matter.
- stall_cnt increments when `out_valid & !out_ready`, holds at all-ones, and is cleared only by reset. It is not cleared by flush.
- When out_valid = 0, the data outputs keep their last values and must be ignored.

## Timing
- Reset (asynchronous assert, synchronous release with clk): state EMPTY, in_ready 1, out_valid 0, out_reg_write 0, out_write_reg 0, out_wb_data 0, fwd_valid 0, stall_cnt 0. Skid contents are zeroed.
- Latency: an input accepted at edge N appears on the outputs after edge N in EMPTY or ONE+pop.
- Throughput is one entry per cycle with out_ready held at 1.
- in_ready is a flop output with no combinational path from out_ready. An upstream stall therefore takes effect one cycle late, and the skid absorbs it.
- out_* and fwd_* are flop outputs with no combinational input-to-output paths.
- Reset asserted mid-transfer: every entry is lost immediately and the outputs take their reset values without waiting for a clock edge.

## Structure
- Shared pipeline package holds:
  - the MEM/WB entry record/typedef (`wb_data`, `write_reg`, `reg_write`, `valid`)
  - the state encoding EMPTY/ONE/TWO
  - the `REG_AW` default
- One natural sub-module: `wb_entry_reg`, an entry register with load enable and valid clear, instantiated twice (head and skid).
- The stall counter stays inline.

## Test plan
- Reset then single transfer:
  - Stimulus: `in_valid=1`, `alu=32'h0000_1234`, `mem_to_reg=0`, `write_reg=5`, `reg_write=1`, `out_ready=1`.
  - Required: next cycle `out_valid=1`, `out_wb_data=32'h1234`, `out_write_reg=5`, `fwd_valid=1`.
- Load select:
  - Stimulus: `read_data=32'hDEAD_BEEF`, `alu=32'h10`, `mem_to_reg=1`.
  - Required: `out_wb_data=32'hDEAD_BEEF`.
- Backpressure:
  - Stimulus: stream values 1,2,3,… with out_ready held 0 from cycle 2 for 4 cycles.
  - Required: in_ready drops after the skid fills; nothing is lost or reordered; stall_cnt=4.
- r0 suppression:
  - Stimulus: `write_reg=0`, `reg_write=1`.
  - Required: `out_reg_write=0`, `fwd_valid=0`, `out_valid=1`.
- Flush in state TWO coincident with `in_valid=1`.
  - Required: next cycle `out_valid=0`, `in_ready=1`, and the incoming entry never appears.
- Saturation:
  - Stimulus: `CNT_W=3`, out_ready held 0 for 10 cycles.
  - Required: stall_cnt holds at 7.
- Additionally: async reset pulse while in TWO clears the outputs immediately.
